// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encoding 2'd3 is unused; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Adder.sv
// One-bit full-adder cell, shared by the ripple adder and the serial
// controller.
module Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: feeds one operand bit pair per clock, LSB first, through
// a single full-adder cell and assembles the WIDTH-bit sum plus carry-out.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_next;

  Adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // Partial sum with the current bit entering at the MSB; on the last bit
  // this is the complete result.
  assign s_next = {fa_sum, s_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state is assigned with <= so every flop samples
      // pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too; they are few flops and
      // a reset abort must leave no stale partial result behind.
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next[WIDTH-1:1];
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            sum_out  <= s_next;
            cout_out <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=4 and WIDTH=8, with
// scoreboard queues popped on each done pulse.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout_out(cout4)
  );

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  exp_t       q4[$];
  exp_t       q8[$];
  exp_t       e4, e8;
  logic [3:0] last_sum4 = '0;
  logic       last_cout4 = 1'b0;
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboards: each done pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done4 sum=%0h", sum4);
      end else begin
        e4 = q4.pop_front();
        check("sum4", 32'(sum4), 32'(e4.sum[3:0]));
        check("cout4", 32'(cout4), 32'(e4.cout));
        last_sum4  = e4.sum[3:0];
        last_cout4 = e4.cout;
      end
    end
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8 sum=%0h", sum8);
      end else begin
        e8 = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e8.sum));
        check("cout8", 32'(cout8), 32'(e8.cout));
      end
    end
  end

  // One WIDTH=4 operation: latency, busy length, output hold and return to idle.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] es, input logic ec, input string name);
    int lat;
    int busy_cnt;
    bit held;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    q4.push_back('{sum: {4'h0, es}, cout: ec});
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = 0;
    held = 1'b1;
    busy_cnt = busy4 ? 1 : 0;
    while (!done4 && lat < 20) begin
      if (sum4 !== last_sum4 || cout4 !== last_cout4) held = 1'b0;
      @(negedge clk);
      lat++;
      if (busy4) busy_cnt++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({name, "_hold_prev"}, 32'(held), 32'd1);
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(busy4), 32'd0);
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input string name);
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back('{sum: es, cout: ec});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    logic [8:0] tot;
    logic [7:0] ra, rb;
    logic       rc;

    vecs[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
    vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    vecs[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
    vecs[6] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
    vecs[7] = '{4'h6, 4'h9, 1'b0, 4'hF, 1'b0};
    vecs[8] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
    vecs[9] = '{4'hA, 4'h3, 1'b0, 4'hD, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    check("rst_cout4", 32'(cout4), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors; the last two show the held 8 then the new D
    for (int i = 0; i < 10; i++)
      run_op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
              $sformatf("vec%0d", i));

    // start held high through RUN and DONE
    @(negedge clk);
    start4 = 1'b1; a4 = 4'h2; b4 = 4'h2; cin4 = 1'b0;
    q4.push_back('{sum: 8'h04, cout: 1'b0});
    q4.push_back('{sum: 8'h0E, cout: 1'b0});
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h7;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held_first_latency", 32'(lat), 32'd4);
    @(negedge clk);
    check("held_start_ignored_in_done", 32'(busy4), 32'd0);
    @(negedge clk);
    start4 = 1'b0;
    check("held_second_accepted", 32'(busy4), 32'd1);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held_second_latency", 32'(lat), 32'd4);
    @(negedge clk);

    // Reset mid-run
    start4 = 1'b1; a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_sum", 32'(sum4), 32'd0);
    check("abort_cout", 32'(cout4), 32'd0);
    last_sum4 = '0;
    last_cout4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'h5; b4 = 4'h5;
    @(negedge clk);
    check("start_during_reset", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    start4 = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op4(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, "after_abort");

    // WIDTH=8 directed and random
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "w8_wrap");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      tot = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      run_op8(ra, rb, rc, tot[7:0], tot[8], "w8_rand");
    end

    @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
